mem_ext_bridge: RTL

Bridges the core's 128-bit L1 miss/writeback bus to a 32-bit external memory port. It sits directly downstream of the L1 memory path: it consumes the address, opcode and write-data requests, and returns read data and a 2-bit status. It splits each request into 1, 2 or 4 external beats and assembles read data into a 128-bit response. It detects bus errors, misaligned requests and unacknowledged beats (timeout).

---
 rtl/mem_ext_bridge_if.sv | 49 ++++
 rtl/mem_ext_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ext_bridge_if.sv
// Bundle between the L1 miss/writeback path, the bridge and the 32-bit memory.
// slave: bridge side. master: requester plus external memory side.
interface mem_ext_bridge_if;
  logic [31:0]  memAddr;
  logic [4:0]   memOpm;
  logic [127:0] memDataOut;
  logic [127:0] memDataIn;
  logic [1:0]   memOK;
  logic [31:0]  extAddr;
  logic         extReq;
  logic         extWe;
  logic [3:0]   extBe;
  logic [31:0]  extWData;
  logic [31:0]  extRData;
  logic         extAck;
  logic         extErr;

  modport slave (
    input  memAddr,
    input  memOpm,
    input  memDataOut,
    output memDataIn,
    output memOK,
    output extAddr,
    output extReq,
    output extWe,
    output extBe,
    output extWData,
    input  extRData,
    input  extAck,
    input  extErr
  );

  modport master (
    output memAddr,
    output memOpm,
    output memDataOut,
    input  memDataIn,
    input  memOK,
    input  extAddr,
    input  extReq,
    input  extWe,
    input  extBe,
    input  extWData,
    output extRData,
    output extAck,
    output extErr
  );
endinterface

// File: rtl/mem_ext_bridge.sv
// Splits 128-bit L1 requests into 1/2/4 external 32-bit beats.
// Ports: clock, reset (async active-low), bus (mem_ext_bridge_if.slave).
module mem_ext_bridge #(
  parameter int TIMEOUT = 255
) (
  input logic             clock,
  input logic             reset,
  mem_ext_bridge_if.slave bus
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW = (CW_RAW < 8) ? 8 : CW_RAW;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DONE,
    FAULT
  } state_e;

  state_e state_q, state_d;

  logic [31:2]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          load_q, load_d;
  logic [127:0]  wdata_q, wdata_d;
  logic [1:0]    beat_q, beat_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]   mem_ok_q, mem_ok_d;
  logic [127:0] rdata_q, rdata_d;
  logic         ext_req_q, ext_req_d;
  logic         ext_we_q, ext_we_d;
  logic [3:0]   ext_be_q, ext_be_d;
  logic [31:0]  ext_addr_q, ext_addr_d;
  logic [31:0]  ext_wdata_q, ext_wdata_d;

  logic       req_go;
  logic       req_bad;
  logic       last_beat;
  logic       timed_out;
  logic [1:0] beat_nx;

  function automatic logic [31:0] beat_addr(
    input logic [31:2] a,
    input logic [2:0]  sz,
    input logic [1:0]  i
  );
    logic [31:0] r;
    case (sz)
      3'b011:  r = {a[31:3], i[0], 2'b00};
      3'b111:  r = {a[31:4], i, 2'b00};
      default: r = {a[31:2], 2'b00};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [1:0] a,
    input logic [2:0] sz
  );
    logic [3:0] be;
    be = 4'hF;
    unique case (1'b1)
      (sz == 3'b000): be = 4'b0001 << a;
      (sz == 3'b001): be = a[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic [1:0] last_idx(
    input logic [2:0] sz
  );
    logic [1:0] n;
    case (sz)
      3'b011:  n = 2'd1;
      3'b111:  n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  assign req_go = (bus.memOpm[4:3] != 2'b00);

  // Reserved opcode 11 and odd 16-bit addresses never reach the bus.
  assign req_bad = (bus.memOpm[4:3] == 2'b11) ||
                   ((bus.memOpm[2:0] == 3'b001) &&
                    bus.memAddr[0]);

  assign last_beat = (beat_q == last_q);
  assign timed_out = (cnt_q == TO_CNT);
  assign beat_nx   = beat_q + 2'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_go) begin
          state_d = req_bad ? FAULT : BEAT;
        end
      end
      BEAT: begin
        if (bus.extErr) begin
          state_d = FAULT;
        end else if (bus.extAck) begin
          if (last_beat) begin
            state_d = DONE;
          end
        end else if (timed_out) begin
          state_d = FAULT;
        end
      end
      DONE, FAULT: begin
        if (!req_go) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    size_d      = size_q;
    load_d      = load_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_ok_d    = mem_ok_q;
    rdata_d     = rdata_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_be_d    = ext_be_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    unique case (state_q)
      IDLE: begin
        mem_ok_d = OK_READY;
        if (req_go) begin
          addr_d  = bus.memAddr[31:2];
          size_d  = bus.memOpm[2:0];
          load_d  = bus.memOpm[3];
          wdata_d = bus.memDataOut;
          beat_d  = 2'd0;
          last_d  = last_idx(bus.memOpm[2:0]);
          cnt_d   = '0;
          rdata_d = '0;
          if (req_bad) begin
            mem_ok_d = OK_FAULT;
          end else begin
            mem_ok_d    = OK_HOLD;
            ext_req_d   = 1'b1;
            ext_we_d    = bus.memOpm[4];
            ext_be_d    = byte_en(bus.memAddr[1:0],
                                  bus.memOpm[2:0]);
            ext_addr_d  = beat_addr(bus.memAddr[31:2],
                                    bus.memOpm[2:0], 2'd0);
            ext_wdata_d = bus.memDataOut[31:0];
          end
        end
      end
      BEAT: begin
        if (bus.extErr) begin
          ext_req_d = 1'b0;
          mem_ok_d  = OK_FAULT;
          rdata_d   = '0;
        end else if (bus.extAck) begin
          cnt_d = '0;
          if (load_q) begin
            rdata_d[{beat_q, 5'b0} +: 32] = bus.extRData;
          end
          if (last_beat) begin
            ext_req_d = 1'b0;
            mem_ok_d  = OK_OK;
          end else begin
            beat_d      = beat_nx;
            ext_addr_d  = beat_addr(addr_q, size_q, beat_nx);
            ext_wdata_d = wdata_q[{beat_nx, 5'b0} +: 32];
          end
        end else if (timed_out) begin
          ext_req_d = 1'b0;
          mem_ok_d  = OK_FAULT;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE, FAULT: begin
        if (!req_go) begin
          mem_ok_d = OK_READY;
        end
      end
      default: mem_ok_d = OK_READY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      size_q      <= '0;
      load_q      <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      mem_ok_q    <= OK_READY;
      rdata_q     <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_be_q    <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      addr_q      <= addr_d;
      size_q      <= size_d;
      load_q      <= load_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_ok_q    <= mem_ok_d;
      rdata_q     <= rdata_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_be_q    <= ext_be_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
    end
  end

  assign bus.memOK     = mem_ok_q;
  assign bus.memDataIn = rdata_q;
  assign bus.extReq    = ext_req_q;
  assign bus.extWe     = ext_we_q;
  assign bus.extBe     = ext_be_q;
  assign bus.extAddr   = ext_addr_q;
  assign bus.extWData  = ext_wdata_q;

endmodule
